// File: rtl/line_sequencer.sv
// Line sequencer: issues a host-loaded frame of lines to the core one at a time,
// waits for each core_ok (or a watchdog timeout) and captures the core result.
module line_sequencer #(
    parameter int    LINES   = 64,
    parameter int    WIDTH   = 25,
    parameter int    TIMEOUT = 500,
    localparam int   AW      = $clog2(LINES),
    localparam int   TW      = $clog2(TIMEOUT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] line,
    output logic [AW-1:0]    count,
    output logic             core_start,
    input  logic             core_ok,
    input  logic [WIDTH-1:0] core_mem,
    output logic             busy,
    output logic             done,
    output logic             timeout_err
);

    localparam logic [AW-1:0] LAST_LINE  = AW'(LINES - 1);
    localparam logic [TW-1:0] WDOG_LIMIT = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] line_q, line_d;
    logic [TW-1:0]    wdog_q, wdog_d;
    logic             timeout_err_q, timeout_err_d;
    logic [WIDTH-1:0] rd_data_q;
    logic             src_we, res_we, wdog_hit;

    logic [WIDTH-1:0] src_mem [LINES];
    logic [WIDTH-1:0] res_mem [LINES];

    assign wdog_hit = (wdog_q == WDOG_LIMIT);

    // State register and datapath flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            count_q       <= '0;
            line_q        <= '0;
            wdog_q        <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            line_q        <= line_d;
            wdog_q        <= wdog_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Buffers are never cleared, so partial results survive a reset
    always_ff @(posedge clk) begin
        if (src_we) src_mem[wr_addr] <= wr_data;
        if (res_we) res_mem[count_q] <= core_mem;
    end

    always_ff @(posedge clk) begin
        if (rst) rd_data_q <= '0;
        else     rd_data_q <= res_mem[rd_addr];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_ISSUE;
            S_ISSUE:   state_d = S_WAIT;
            S_WAIT:    if (core_ok || wdog_hit) state_d = S_CAPTURE;
            S_CAPTURE: state_d = (count_q == LAST_LINE) ? S_FINISH : S_ISSUE;
            S_FINISH:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        count_d       = count_q;
        line_d        = line_q;
        wdog_d        = wdog_q;
        timeout_err_d = timeout_err_q;
        src_we        = 1'b0;
        res_we        = 1'b0;
        case (state_q)
            S_IDLE: begin
                src_we = wr_en;
                if (start) begin
                    count_d       = '0;
                    timeout_err_d = 1'b0;
                end
            end
            S_ISSUE: wdog_d = '0;
            S_WAIT: begin
                wdog_d = wdog_q + TW'(1);
                // A core_ok on the limit cycle counts as success
                if (core_ok || wdog_hit) res_we = 1'b1;
                if (!core_ok && wdog_hit) timeout_err_d = 1'b1;
            end
            S_CAPTURE: if (count_q != LAST_LINE) count_d = count_q + AW'(1);
            default: ;
        endcase
        // Load the line on entry so line/count are both valid during ISSUE
        if (state_d == S_ISSUE) line_d = src_mem[count_d];
    end

    always_comb begin
        core_start = (state_q == S_ISSUE);
        busy       = (state_q != S_IDLE);
        done       = (state_q == S_FINISH);
    end

    assign line        = line_q;
    assign count       = count_q;
    assign timeout_err = timeout_err_q;
    assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_line_sequencer.sv
// Directed bench for line_sequencer with a simple core responder model.
module tb_line_sequencer;

    localparam int          TIMEOUT  = 500;
    localparam logic [24:0] IDLE_MEM = 25'h1234567;

    logic        clk = 1'b0;
    logic        rst, start, wr_en;
    logic [5:0]  wr_addr, rd_addr;
    logic [24:0] wr_data;
    logic [24:0] rd_data, line;
    logic [5:0]  count;
    logic        core_start, busy, done, timeout_err;
    logic        core_ok  = 1'b0;
    logic [24:0] core_mem = IDLE_MEM;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [24:0] src_m [64];

    line_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data), .line(line),
        .count(count), .core_start(core_start), .core_ok(core_ok),
        .core_mem(core_mem), .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Monitor: log every core_start pulse and count done pulses
    logic [5:0]  log_cnt  [$];
    logic [24:0] log_line [$];
    int          log_cyc  [$];
    int          done_cnt     = 0;
    int          double_start = 0;
    bit          prev_cs      = 1'b0;

    always @(negedge clk) begin
        if (core_start === 1'b1) begin
            log_cnt.push_back(count);
            log_line.push_back(line);
            log_cyc.push_back(cyc);
            if (prev_cs) double_start++;
        end
        prev_cs = (core_start === 1'b1);
        if (done === 1'b1) done_cnt++;
    end

    // Core model: answers ~line after a delay; can skip a line or answer late
    int          skip_idx = -1;
    int          late_idx = -1;
    int          late_off = 0;
    int          cm_delay = 0;
    bit          cm_armed = 1'b0;
    logic [24:0] cm_line;

    always @(negedge clk) begin
        core_ok  = 1'b0;
        core_mem = IDLE_MEM;
        if (core_start === 1'b1) begin
            cm_line  = line;
            cm_armed = (int'(count) != skip_idx);
            cm_delay = (int'(count) == late_idx) ? TIMEOUT + late_off : 3;
        end else if (cm_armed) begin
            cm_delay--;
            if (cm_delay == 0) begin
                core_ok  = 1'b1;
                core_mem = ~cm_line;
                cm_armed = 1'b0;
            end
        end
    end

    task automatic load_image();
        for (int i = 0; i < 64; i++) begin
            src_m[i] = 25'(i * 32'h20001);
            @(negedge clk);
            wr_en = 1'b1; wr_addr = 6'(i); wr_data = src_m[i];
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_frame(input int budget, output bit ok, output logic busy_seen);
        log_cnt.delete(); log_line.delete(); log_cyc.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        busy_seen = busy;
        wait_done(budget, ok);
    endtask

    task automatic read_res(input logic [5:0] a, output logic [24:0] d);
        @(negedge clk); rd_addr = a;
        @(negedge clk); d = rd_data;
    endtask

    task automatic wait_line(input int idx, input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (core_start === 1'b1 && int'(count) == idx) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL reset_core_start got=%b want=0", core_start); end
        checks++; if (line !== 25'h0) begin errors++; $display("FAIL reset_line got=%h want=0", line); end
        checks++; if (count !== 6'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", count); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got=%b want=0", timeout_err); end
        checks++; if (rd_data !== 25'h0) begin errors++; $display("FAIL reset_rd_data got=%h want=0", rd_data); end
        rst = 1'b0;
    endtask

    task automatic test_frame();
        bit ok; logic b; int base; logic [24:0] d;
        skip_idx = -1; late_idx = -1;
        base = done_cnt;
        run_frame(2000, ok, b);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL frame_done_seen got=%b want=1", ok); end
        checks++; if (b !== 1'b1) begin errors++; $display("FAIL frame_busy_after_start got=%b want=1", b); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL frame_timeout_err got=%b want=0", timeout_err); end
        checks++; if (log_cnt.size() != 64) begin errors++; $display("FAIL frame_pulses got=%0d want=64", log_cnt.size()); end
        if (log_cnt.size() == 64) begin
            for (int i = 0; i < 64; i++) begin
                checks++; if (log_cnt[i] !== 6'(i)) begin errors++; $display("FAIL frame_count[%0d] got=%0d want=%0d", i, log_cnt[i], i); end
                checks++; if (log_line[i] !== src_m[i]) begin errors++; $display("FAIL frame_line[%0d] got=%h want=%h", i, log_line[i], src_m[i]); end
            end
        end
        checks++; if (log_cyc[1] - log_cyc[0] != 5) begin errors++; $display("FAIL frame_line_period got=%0d want=5", log_cyc[1] - log_cyc[0]); end
        repeat (4) @(negedge clk);
        checks++; if (done_cnt - base != 1) begin errors++; $display("FAIL frame_done_once got=%0d want=1", done_cnt - base); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frame_busy_end got=%b want=0", busy); end
        checks++; if (double_start != 0) begin errors++; $display("FAIL frame_core_start_width got=%0d want=0", double_start); end
        read_res(6'd17, d);
        checks++; if (d !== ~src_m[17]) begin errors++; $display("FAIL frame_res17 got=%h want=%h", d, ~src_m[17]); end
    endtask

    task automatic test_timeout();
        bit ok; logic b; logic [24:0] d;
        skip_idx = 5;
        run_frame(3000, ok, b);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL to_done_seen got=%b want=1", ok); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_timeout_err got=%b want=1", timeout_err); end
        checks++; if (log_cnt.size() != 64) begin errors++; $display("FAIL to_pulses got=%0d want=64", log_cnt.size()); end
        checks++; if (log_cnt[63] !== 6'd63) begin errors++; $display("FAIL to_last_count got=%0d want=63", log_cnt[63]); end
        checks++; if (log_cyc[6] - log_cyc[5] != TIMEOUT + 2) begin errors++; $display("FAIL to_wait_len got=%0d want=%0d", log_cyc[6] - log_cyc[5], TIMEOUT + 2); end
        skip_idx = -1;
        read_res(6'd5, d);
        checks++; if (d !== IDLE_MEM) begin errors++; $display("FAIL to_res5 got=%h want=%h", d, IDLE_MEM); end
        read_res(6'd6, d);
        checks++; if (d !== ~src_m[6]) begin errors++; $display("FAIL to_res6 got=%h want=%h", d, ~src_m[6]); end
    endtask

    task automatic test_ignored_inputs();
        bit ok, found; logic b; int base; logic [24:0] d;
        log_cnt.delete(); log_line.delete(); log_cyc.delete();
        base = done_cnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_line(10, 200, found);
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL ign_reach_line10 got=%b want=1", found); end
        @(negedge clk);
        start = 1'b1; wr_en = 1'b1; wr_addr = 6'd0; wr_data = 25'h1FFFFFF;
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        wait_done(2000, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ign_done_seen got=%b want=1", ok); end
        checks++; if (log_cnt.size() != 64) begin errors++; $display("FAIL ign_pulses got=%0d want=64", log_cnt.size()); end
        if (log_cnt.size() == 64) begin
            for (int i = 0; i < 64; i++) begin
                checks++; if (log_cnt[i] !== 6'(i)) begin errors++; $display("FAIL ign_count[%0d] got=%0d want=%0d", i, log_cnt[i], i); end
            end
        end
        repeat (3) @(negedge clk);
        checks++; if (done_cnt - base != 1) begin errors++; $display("FAIL ign_done_once got=%0d want=1", done_cnt - base); end
        run_frame(2000, ok, b);
        checks++; if (log_line[0] !== src_m[0]) begin errors++; $display("FAIL ign_src0_kept got=%h want=%h", log_line[0], src_m[0]); end
        read_res(6'd0, d);
        checks++; if (d !== ~src_m[0]) begin errors++; $display("FAIL ign_res0 got=%h want=%h", d, ~src_m[0]); end
    endtask

    task automatic test_reset_mid_frame();
        bit ok, found; logic b; int base, n; logic [24:0] d;
        log_cnt.delete(); log_line.delete(); log_cyc.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_line(30, 400, found);
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL rstm_reach_line30 got=%b want=1", found); end
        base = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstm_busy got=%b want=0", busy); end
        checks++; if (count !== 6'd0) begin errors++; $display("FAIL rstm_count got=%0d want=0", count); end
        checks++; if (line !== 25'h0) begin errors++; $display("FAIL rstm_line got=%h want=0", line); end
        n = log_cnt.size();
        repeat (10) @(negedge clk);
        checks++; if (done_cnt != base) begin errors++; $display("FAIL rstm_no_done got=%0d want=%0d", done_cnt, base); end
        checks++; if (log_cnt.size() != n) begin errors++; $display("FAIL rstm_no_issue got=%0d want=%0d", log_cnt.size(), n); end
        run_frame(2000, ok, b);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rstm_clean_done got=%b want=1", ok); end
        checks++; if (log_cnt.size() != 64) begin errors++; $display("FAIL rstm_clean_pulses got=%0d want=64", log_cnt.size()); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rstm_clean_timeout_err got=%b want=0", timeout_err); end
        read_res(6'd40, d);
        checks++; if (d !== ~src_m[40]) begin errors++; $display("FAIL rstm_res40 got=%h want=%h", d, ~src_m[40]); end
    endtask

    task automatic test_watchdog_limit();
        bit ok; logic b; logic [24:0] d;
        late_idx = 7; late_off = 0;
        run_frame(3000, ok, b);
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL wd_edge_timeout_err got=%b want=0", timeout_err); end
        checks++; if (log_cyc[8] - log_cyc[7] != TIMEOUT + 2) begin errors++; $display("FAIL wd_edge_wait_len got=%0d want=%0d", log_cyc[8] - log_cyc[7], TIMEOUT + 2); end
        read_res(6'd7, d);
        checks++; if (d !== ~src_m[7]) begin errors++; $display("FAIL wd_edge_res7 got=%h want=%h", d, ~src_m[7]); end
        late_off = 1;
        run_frame(3000, ok, b);
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL wd_late_timeout_err got=%b want=1", timeout_err); end
        read_res(6'd7, d);
        checks++; if (d !== IDLE_MEM) begin errors++; $display("FAIL wd_late_res7 got=%h want=%h", d, IDLE_MEM); end
        late_idx = -1; late_off = 0;
    endtask

    task automatic test_back_to_back();
        bit ok; logic b;
        skip_idx = 5;
        run_frame(3000, ok, b);
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL b2b_first_timeout_err got=%b want=1", timeout_err); end
        skip_idx = -1;
        log_cnt.delete(); log_line.delete(); log_cyc.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got=%b want=1", busy); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL b2b_err_cleared got=%b want=0", timeout_err); end
        wait_done(2000, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_done_seen got=%b want=1", ok); end
        checks++; if (log_cnt.size() != 64) begin errors++; $display("FAIL b2b_pulses got=%0d want=64", log_cnt.size()); end
        checks++; if (log_cnt[0] !== 6'd0) begin errors++; $display("FAIL b2b_first_count got=%0d want=0", log_cnt[0]); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL b2b_end_timeout_err got=%b want=0", timeout_err); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; wr_en = 1'b0;
        wr_addr = '0; wr_data = '0; rd_addr = '0;
        test_reset();
        load_image();
        test_frame();
        test_timeout();
        test_ignored_inputs();
        test_reset_mid_frame();
        test_watchdog_limit();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/line_sequencer.md
Name: line_sequencer

Overview:
- Hardware counterpart of the bench-side line feeder for the Controller/Datapath core.
- Holds a 64-line by 25-bit state image loaded by a host. On start, issues lines 0..63 to the core one at a time (line + count), and waits per line for the core's ok pulse or a watchdog timeout.
- Captures each 25-bit core result (mem) into a result buffer, which the host reads back after done.

Parameters:
- LINES, 64, number of lines per frame; count/address width is log2(LINES) = 6.
- WIDTH, 25, bits per line.
- TIMEOUT, 500, max cycles to wait for core_ok per line (matches the 20000 ns / 40 ns bench budget).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- wr_en  in  1  host write strobe into the source buffer.
- wr_addr  in  6  source buffer write address.
- wr_data  in  25  source line data.
- rd_addr  in  6  result buffer read address.
- rd_data  out  25  result line at rd_addr, registered, 1-cycle read latency.
- line  out  25  current line presented to the core.
- count  out  6  index of the current line.
- core_start  out  1  one-cycle pulse telling the core that line/count are valid.
- core_ok  in  1  core completion pulse for the current line.
- core_mem  in  25  core result, valid in the core_ok cycle.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last line is captured.
- timeout_err  out  1  sticky; set if any line timed out; cleared by the next accepted start.

Behaviour:
- Reset values:
  - line = 0, count = 0, core_start = 0, busy = 0, done = 0, timeout_err = 0, rd_data = 0.
  - FSM returns to IDLE; watchdog counter = 0.
  - Buffer contents are not cleared.
- FSM states: IDLE, ISSUE, WAIT, CAPTURE, FINISH.
- IDLE:
  - wr_en writes src[wr_addr] <= wr_data.
  - start moves to ISSUE with count <= 0, timeout_err <= 0, busy <= 1.
- ISSUE (1 cycle):
  - line <= src[count]; core_start pulses for exactly 1 cycle, aligned with valid line/count.
  - Clear the watchdog; go to WAIT.
- WAIT:
  - The watchdog increments each cycle.
  - core_ok = 1: latch core_mem into res[count]; go to CAPTURE.
  - Watchdog reaches TIMEOUT-1 with no core_ok: write res[count] <= core_mem as sampled that cycle, set timeout_err, go to CAPTURE.
  - core_ok in the same cycle as the watchdog limit: treated as success, no error.
- CAPTURE (1 cycle):
  - count = LINES-1: go to FINISH.
  - Otherwise: count <= count+1, go to ISSUE.
- FINISH: done pulses 1 cycle, busy <= 0, count holds 63, go to IDLE.
- Per-line latency: ISSUE to the next ISSUE = (WAIT cycles) + 2.
- Line and count stability: line and count hold stable from ISSUE through CAPTURE; the core may sample them any cycle.
- Ignored inputs:
  - start while busy: ignored, no restart.
  - wr_en while busy: ignored, source image protected.
  - core_ok outside WAIT: ignored.
- Read port: rd_data <= res[rd_addr] every cycle in all states. Reads during a frame return partially updated data.
- Count wrap: count never wraps within a frame; a new start resets it to 0.
- rst mid-frame: aborts next cycle to IDLE with the reset values above; no done pulse; partial results remain in res.

Test Plan:
- Load src[i] = i*0x2_0001 for i = 0..63; start; core model returns core_mem = ~line with core_ok 3 cycles after core_start -> 64 core_start pulses with count 0..63, done once, timeout_err = 0, rd_data at rd_addr 17 = ~src[17] (25-bit).
- Core model never asserts core_ok for count = 5 only -> that line waits exactly TIMEOUT cycles, timeout_err = 1 at done; other lines correct; sequence continues to count 63.
- Assert start and wr_en (addr 0, data 0x1FFFFFF) during WAIT at count = 10 -> no restart; src[0] unchanged on the next frame; core_start count sequence unbroken.
- rst high for 1 cycle at count = 30 -> next cycle busy = 0, count = 0, line = 0, no done; a subsequent start runs a full clean frame.
- core_ok coincident with the watchdog limit (core_ok exactly TIMEOUT-1 cycles into WAIT) -> result captured, timeout_err stays 0.
- Back-to-back frames: start on the cycle after done -> second frame accepted, timeout_err cleared, count restarts at 0.
